// File: rtl/aes_req_sched_if.sv
// Request, datapath-control and response signals of the AES job scheduler.
// master: the scheduler side; slave: requesters, round datapath and consumer.
interface aes_req_sched_if;
    logic         req0_valid;
    logic         req0_ready;
    logic [127:0] req0_pt;
    logic [127:0] req0_key;
    logic         req1_valid;
    logic         req1_ready;
    logic [127:0] req1_pt;
    logic [127:0] req1_key;
    logic         dp_load;
    logic         dp_round;
    logic         dp_final;
    logic [7:0]   dp_rcon;
    logic [127:0] dp_pt;
    logic [127:0] dp_key;
    logic [127:0] dp_state;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [127:0] rsp_ct;
    logic         rsp_id;
    logic         busy;

    modport master (
        input  req0_valid, req0_pt, req0_key,
        input  req1_valid, req1_pt, req1_key,
        input  dp_state, rsp_ready,
        output req0_ready, req1_ready,
        output dp_load, dp_round, dp_final, dp_rcon, dp_pt, dp_key,
        output rsp_valid, rsp_ct, rsp_id, busy
    );

    modport slave (
        output req0_valid, req0_pt, req0_key,
        output req1_valid, req1_pt, req1_key,
        output dp_state, rsp_ready,
        input  req0_ready, req1_ready,
        input  dp_load, dp_round, dp_final, dp_rcon, dp_pt, dp_key,
        input  rsp_valid, rsp_ct, rsp_id, busy
    );
endinterface

// File: rtl/aes_req_sched.sv
// Round-robin scheduler/sequencer for the shared iterative AES-128 round datapath.
// Latency: response valid NUM_ROUNDS+2 cycles after the accept cycle; one job per NUM_ROUNDS+3 cycles.
// Backpressure: response held stable until rsp_ready; no request is accepted outside IDLE.
module aes_req_sched #(
    parameter int NUM_ROUNDS = 10
) (
    input  logic            clk,
    input  logic            rst,
    aes_req_sched_if.master bus
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_ROUND = 3'd2;
    localparam logic [2:0] S_FINAL = 3'd3;
    localparam logic [2:0] S_RESP  = 3'd4;

    localparam logic [3:0] LAST_MID = 4'(NUM_ROUNDS - 1);

    logic [2:0]   state;
    logic [2:0]   state_nxt;
    logic [3:0]   round_cnt;
    logic [7:0]   rcon;
    logic         last_grant;
    logic [127:0] pt_q;
    logic [127:0] key_q;
    logic         id_q;
    logic         grant0;
    logic         grant1;
    logic         idle_open;
    logic         accept;

    // Contention goes to the requester not served last; a lone requester always wins.
    assign grant0    = bus.req0_valid & (~bus.req1_valid | last_grant);
    assign grant1    = bus.req1_valid & (~bus.req0_valid | ~last_grant);
    assign idle_open = (state == S_IDLE) & ~rst;

    assign bus.req0_ready = idle_open & grant0;
    assign bus.req1_ready = idle_open & grant1;
    assign accept         = (bus.req0_valid & bus.req0_ready) | (bus.req1_valid & bus.req1_ready);

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (accept) state_nxt = S_LOAD;
            S_LOAD:  state_nxt = (NUM_ROUNDS > 1) ? S_ROUND : S_FINAL;
            S_ROUND: if (round_cnt == LAST_MID) state_nxt = S_FINAL;
            S_FINAL: state_nxt = S_RESP;
            S_RESP:  if (bus.rsp_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            round_cnt  <= 4'd0;
            rcon       <= 8'h01;
            last_grant <= 1'b1;
            pt_q       <= '0;
            key_q      <= '0;
            id_q       <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                pt_q       <= grant1 ? bus.req1_pt  : bus.req0_pt;
                key_q      <= grant1 ? bus.req1_key : bus.req0_key;
                id_q       <= grant1;
                last_grant <= grant1;
            end
            if (state == S_LOAD) begin
                round_cnt <= 4'd1;
                rcon      <= 8'h01;
            end else if (state == S_ROUND) begin
                // rcon tracks round_cnt so FINAL sees rcon(NUM_ROUNDS) without a table.
                round_cnt <= round_cnt + 4'd1;
                rcon      <= {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1B : 8'h00);
            end
        end
    end

    assign bus.dp_load   = (state == S_LOAD);
    assign bus.dp_round  = (state == S_ROUND);
    assign bus.dp_final  = (state == S_FINAL);
    assign bus.dp_rcon   = (bus.dp_round | bus.dp_final) ? rcon : 8'h00;
    assign bus.dp_pt     = pt_q;
    assign bus.dp_key    = key_q;
    assign bus.rsp_valid = (state == S_RESP);
    assign bus.rsp_ct    = bus.rsp_valid ? bus.dp_state : '0;
    assign bus.rsp_id    = id_q;
    assign bus.busy      = (state != S_IDLE);

endmodule
